// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the architectural PC and issues valid/ready instruction fetch requests.
// Optional build macro MISALIGN_TRAP_EN: a misaligned redirect halts the block with a sticky trap flag.
module pc_fetch_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt_req,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] pc_out,
  output logic            halted,
  output logic [31:0]     fetch_count,
  output logic            misalign_trap
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [31:0]     count_r;
  logic            valid_r;
  logic            halted_r;
  logic            fire_s;
`ifdef MISALIGN_TRAP_EN
  logic            trap_r;
`endif

  // Stall must kill the request in the same cycle, so it gates the registered valid combinationally.
  assign fetch_valid = valid_r & ~stall;
  assign fire_s      = fetch_valid & fetch_ready;
  assign fetch_pc    = pc_r;
  assign pc_out      = pc_r;
  assign halted      = halted_r;
  assign fetch_count = count_r;
`ifdef MISALIGN_TRAP_EN
  assign misalign_trap = trap_r;
`else
  assign misalign_trap = 1'b0;
`endif

  // Sequencer FSM: PC, fetch counter and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_BOOT;
      pc_r     <= RESET_PC;
      count_r  <= 32'd0;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r <= ST_FETCH;
          valid_r <= 1'b1;
        end
        ST_FETCH: begin
          if (fire_s) begin
            count_r <= count_r + 32'd1;
          end
          // Halt outranks redirect; redirect outranks the sequential advance.
          if (halt_req) begin
            state_r  <= ST_HALT;
            valid_r  <= 1'b0;
            halted_r <= 1'b1;
          end else if (redirect_valid) begin
`ifdef MISALIGN_TRAP_EN
            if (redirect_target[1:0] != 2'b00) begin
              state_r  <= ST_HALT;
              valid_r  <= 1'b0;
              halted_r <= 1'b1;
              trap_r   <= 1'b1;
            end else begin
              pc_r <= redirect_target;
            end
`else
            pc_r <= redirect_target & ALIGN_MASK;
`endif
          end else if (fire_s) begin
            pc_r <= pc_r + PC_STEP;
          end
        end
        ST_HALT: begin
          valid_r  <= 1'b0;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_BOOT;
          valid_r  <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed scenarios followed by randomized traffic,
// checked against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] pc_out;
  logic        halted;
  logic [31:0] fetch_count;
  logic        misalign_trap;

  pc_fetch_sequencer #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .fetch_pc        (fetch_pc),
    .pc_out          (pc_out),
    .halted          (halted),
    .fetch_count     (fetch_count),
    .misalign_trap   (misalign_trap)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] count;
    logic        halted;
    logic        trap;
  } exp_t;

  exp_t sb_q[$];
  exp_t me;
  int   tests  = 0;
  int   failed = 0;
  int   ncyc   = 0;

  // Reference model state: mode 0 = boot, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_trap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, ncyc, got, exp);
    end
  endtask

  // One clock of stimulus: drive inputs, record what the outputs must show, then advance the model.
  task automatic cycle(input logic rst, input logic st, input logic rv, input logic [31:0] rt,
                       input logic hr, input logic rd);
    exp_t e;
    logic fire;
    @(negedge clk);
    reset = rst; stall = st; redirect_valid = rv; redirect_target = rt;
    halt_req = hr; fetch_ready = rd;
    if (!rst) begin
      m_mode = 0; m_pc = RST_PC; m_count = 32'd0; m_trap = 1'b0;
    end
    e.valid  = (m_mode == 1) && !st;
    e.pc     = m_pc;
    e.count  = m_count;
    e.halted = (m_mode == 2);
    e.trap   = m_trap;
    sb_q.push_back(e);
    if (rst) begin
      fire = e.valid && rd;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (fire) m_count = m_count + 32'd1;
        if (hr) begin
          m_mode = 2;
        end else if (rv) begin
`ifdef MISALIGN_TRAP_EN
          if (rt % 4 != 0) begin
            m_trap = 1'b1;
            m_mode = 2;
          end else begin
            m_pc = rt;
          end
`else
          m_pc = rt - (rt % 4);
`endif
        end else if (fire) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // Monitor: pops one expected record per cycle and compares every visible output.
  always @(negedge clk) begin
    #2;
    ncyc++;
    if (sb_q.size() > 0) begin
      me = sb_q.pop_front();
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, me.valid});
      chk("fetch_pc", fetch_pc, me.pc);
      chk("pc_out", pc_out, me.pc);
      chk("fetch_count", fetch_count, me.count);
      chk("halted", {31'd0, halted}, {31'd0, me.halted});
      chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, me.trap});
    end
  end

  initial begin
    logic        r_rst, r_st, r_rv, r_hr, r_rd;
    logic [31:0] r_rt;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    halt_req = 1'b0; fetch_ready = 1'b0;
    m_mode = 0; m_pc = RST_PC; m_count = 32'd0; m_trap = 1'b0;

    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    // Boot then fetches at 0 and 4.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    // Memory back-pressure at PC 8.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    // Stall at PC 16 while memory is ready.
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    // Redirect coincident with a fire at PC 20, then a redirect under stall.
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0180, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    // Halt beats a same-cycle redirect; the fire in that cycle still counts.
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    // Misaligned redirect.
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    // PC wrap from the top of the address space.
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 59) != 0);
      r_st  = ($urandom_range(0, 4) == 0);
      r_rv  = ($urandom_range(0, 9) == 0);
      r_rt  = $urandom;
      if ($urandom_range(0, 3) != 0) r_rt[1:0] = 2'b00;
      r_hr  = ($urandom_range(0, 99) == 0);
      r_rd  = ($urandom_range(0, 9) < 7);
      cycle(r_rst, r_st, r_rv, r_rt, r_hr, r_rd);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    #5;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Owns the architectural program counter and feeds the instruction-fetch side of the datapath. Each cycle it presents the current PC to instruction memory over a valid/ready handshake. It advances the PC by 4 on each accepted fetch and loads a new PC on branch/jump redirects. It also supports stall, halt and a fetch counter for debug.

Parameters:
XLEN, 32, datapath/PC width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low; asserted when 0.
stall  input  1  hold PC and suppress fetch requests (hazard unit).
redirect_valid  input  1  load redirect_target as next PC (branch taken/jump).
redirect_target  input  XLEN  redirect destination.
halt_req  input  1  stop fetching permanently until reset.
fetch_valid  output  1  fetch request valid.
fetch_ready  input  1  instruction memory accepts request.
fetch_pc  output  XLEN  address of request; equals current PC.
pc_out  output  XLEN  current PC (to datapath/adder).
halted  output  1  block in HALT state.
fetch_count  output  32  number of accepted fetches since reset.
misalign_trap  output  1  sticky misaligned-redirect flag (MISALIGN_TRAP_EN only; tied 0 otherwise).

Behaviour:
- Reset (reset==0, async): PC=RESET_PC, state=BOOT, fetch_valid=0, halted=0, fetch_count=0, misalign_trap=0.
- fetch_pc and pc_out are always the PC register; both are registered outputs.
- fetch_valid is registered logic ANDed with !stall, so it is 0 in any cycle stall=1.
- States:
  - BOOT: fetch_valid=0. Moves to FETCH on the next edge, so the first request appears 1 cycle after reset release.
  - FETCH: fetch_valid=!stall. Fire = fetch_valid & fetch_ready.
  - HALT: fetch_valid=0, halted=1, PC frozen. Exits only via reset.
- Per-edge priority in FETCH, highest first:
  1. halt_req=1: go to HALT. PC unchanged and any redirect in the same cycle is ignored. fetch_count still increments if fire occurs in that cycle.
  2. redirect_valid=1: PC <= redirect_target. Accepted even when stall=1 or fire=1. A same-cycle fire counts, but the pc+4 advance is discarded.
  3. fire: PC <= PC + 4, modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).
  4. Otherwise PC holds. fetch_valid and fetch_pc remain stable until fire.
- Redirect is the only event that changes fetch_pc while a request is pending without a handshake.
- fetch_count: +1 per fire, wraps at 2^32. It is not affected by stall or redirect.
- redirect_valid and halt_req are ignored in BOOT and HALT.
- Reset asserted mid-handshake drops fetch_valid immediately (async). No completion is implied.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a redirect with redirect_target[1:0]!=0, accepted at priority 2, does not load the PC. The block instead sets misalign_trap=1 (sticky until reset) and enters HALT.
- Undefined: no check. PC <= {redirect_target[XLEN-1:2], 2'b00}, misalign_trap tied to 0.

Test Plan:
- Reset release, fetch_ready=1 constant -> fetch_valid rises 1 cycle after release; fetch_pc = 0,4,8,12 on consecutive cycles; fetch_count=4 after 4 fires.
- fetch_ready=0 for 3 cycles at PC=8 -> fetch_valid=1, fetch_pc=8 held stable; after ready=1, PC=12, count +1 only.
- stall=1 for 2 cycles at PC=16 with ready=1 -> fetch_valid=0, PC=16 held, count unchanged; resumes at 16.
- redirect_valid=1, target=0x100 in same cycle as fire at PC=20 -> next fetch_pc=0x100 (not 24); count +1. Redirect during stall is also taken.
- halt_req and redirect(0x200) in same cycle at PC=0x40 -> halted=1, fetch_valid=0, PC stays 0x40 indefinitely. Reset pulse returns PC=RESET_PC.
- With MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_trap=1, halted=1, PC unchanged. Without the macro -> PC=0x100, no trap.
